// File: rtl/pipo_pkg.sv
// pipo_pkg: shared FSM states, default sizes and index-width helper for the pipo load arbiter.
package pipo_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;
  localparam int WIDE_D = 4;
  localparam int NREQ_D = 4;
  localparam int HOLD_D = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipo_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request at or after pointer p.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   p,
  output logic            valid,
  output logic [IW-1:0]   win
);
  always_comb begin
    valid = 1'b0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(p) + k) % NREQ]) begin
        valid = 1'b1;
        win = IW'((int'(p) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin load controller driving one shared pipo register's go/sh inputs.
// Define PIPO_ARB_PRIO_EN to give requester 0 fixed top priority over a 1..NREQ-1 round robin.
module pipo_load_arbiter
  import pipo_pkg::*;
#(
  parameter int WIDE = WIDE_D,
  parameter int NREQ = NREQ_D,
  parameter int HOLD = HOLD_D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDE-1:0]     data,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDE-1:0]          go,
  output logic                     sh,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(HOLD + 1);
  state_t state, state_n;
  logic [IW-1:0] p, p_n, pw, w;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] rr_req;
  logic pv, valid;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(rr_req), .p(p), .valid(pv), .win(pw));
`ifdef PIPO_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and leaves the pointer where it was.
  assign rr_req = {req[NREQ-1:1], 1'b0};
  assign valid = req[0] | pv;
  assign w = req[0] ? '0 : pw;
  assign p_n = req[0] ? p : (pw == IW'(NREQ - 1)) ? IW'(1) : pw + IW'(1);
`else
  assign rr_req = req;
  assign valid = pv;
  assign w = pw;
  assign p_n = (pw == IW'(NREQ - 1)) ? '0 : pw + IW'(1);
`endif
  assign busy = (state != S_IDLE);
  always_comb begin
    state_n = (state == S_IDLE) ? (valid ? S_LOAD : S_IDLE) :
              (state == S_LOAD) ? S_HOLD :
              (cnt == '0) ? S_IDLE : S_HOLD;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go <= '0;
      sh <= 1'b0;
      gnt <= '0;
      owner <= '0;
      p <= '0;
      cnt <= '0;
    end else begin
      sh <= 1'b0;
      gnt <= '0;
      if (state == S_IDLE && valid) begin
        go <= data[w*WIDE +: WIDE];
        owner <= w;
        gnt <= NREQ'(1) << w;
        sh <= 1'b1;
        p <= p_n;
      end
      if (state == S_LOAD) cnt <= CW'(HOLD - 1);
      else if (state == S_HOLD && cnt != '0) cnt <= cnt - CW'(1);
    end
  end
endmodule
